// File: rtl/wb_frame_reader.sv
// rtl/wb_frame_reader.sv - Wishbone master reading one stored camera frame out as a pixel stream
// Optional feature macro: FRAME_READER_PREFETCH_EN (second word buffer, fetch overlapped with unpack)
// Ports:
//   clk, rst_n                    system clock, asynchronous active-low reset
//   start, abort, rd_addr_start   frame control: begin at byte address / cancel frame
//   busy, done                    frame in progress / 1-cycle pulse after last pixel handshake
//   timestamp, ts_vld             frame timestamp word and its update pulse
//   m_wb_cyc/stb/adr/we           Wishbone read master request (we tied low)
//   m_i_wb_dat, m_wb_ack          Wishbone read data and acknowledge
//   px_dat/px_vld/px_rdy          8-bit pixel stream with valid/ready handshake
//   px_sof/px_eol/px_eof          start-of-frame, end-of-line, end-of-frame qualifiers
module wb_frame_reader #(
    parameter int ADR_WIDTH = 15,
    parameter int ROWS      = 120,
    parameter int COLS      = 160
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADR_WIDTH-1:0] rd_addr_start,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          timestamp,
    output logic                 ts_vld,
    output logic                 m_wb_cyc,
    output logic                 m_wb_stb,
    output logic [ADR_WIDTH-1:0] m_wb_adr,
    output logic                 m_wb_we,
    input  logic [31:0]          m_i_wb_dat,
    input  logic                 m_wb_ack,
    output logic [7:0]           px_dat,
    output logic                 px_vld,
    input  logic                 px_rdy,
    output logic                 px_sof,
    output logic                 px_eol,
    output logic                 px_eof
);

`ifdef FRAME_READER_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    localparam int WORDS = ROWS * COLS / 4;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WCW   = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, UNPACK} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 cyc_q;
    logic [ADR_WIDTH-1:0] adr_q;
    logic [31:0]          cur_word;
    logic [31:0]          nxt_word;
    logic                 nxt_vld;
    logic [1:0]           byte_idx;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WCW-1:0]       fetch_cnt;
    logic                 ts_phase;
    logic                 busy_q;
    logic                 done_q;
    logic                 ts_vld_q;
    logic [31:0]          ts_q;

    // stb is never dropped while cyc is high, so one register drives both.
    logic ack_hit, px_hs, last_byte, col_last, row_last, can_prefetch;
    assign ack_hit      = cyc_q & m_wb_ack;
    assign px_hs        = (state == UNPACK) & px_rdy;
    assign last_byte    = px_hs & (byte_idx == 2'd3);
    assign col_last     = (col == CW'(COLS - 1));
    assign row_last     = (row == RW'(ROWS - 1));
    assign can_prefetch = PREFETCH && !nxt_vld && (fetch_cnt != WCW'(WORDS));

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = FETCH;
                FETCH:   if (ack_hit && !ts_phase) state_nx = UNPACK;
                UNPACK: begin
                    if (last_byte) begin
                        if (col_last && row_last)                 state_nx = IDLE;
                        else if (PREFETCH && (nxt_vld || ack_hit)) state_nx = UNPACK;
                        else                                      state_nx = FETCH;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            cur_word  <= '0;
            nxt_word  <= '0;
            nxt_vld   <= 1'b0;
            byte_idx  <= '0;
            col       <= '0;
            row       <= '0;
            fetch_cnt <= '0;
            ts_phase  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ts_vld_q  <= 1'b0;
            ts_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            ts_vld_q <= 1'b0;
            if (abort) begin
                cyc_q   <= 1'b0;
                busy_q  <= 1'b0;
                nxt_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            adr_q     <= rd_addr_start;
                            cyc_q     <= 1'b1;
                            busy_q    <= 1'b1;
                            ts_phase  <= 1'b1;
                            fetch_cnt <= '0;
                            col       <= '0;
                            row       <= '0;
                            byte_idx  <= '0;
                            nxt_vld   <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (ack_hit) begin
                            cyc_q <= 1'b0;
                            adr_q <= adr_q + ADR_WIDTH'(4);
                            if (ts_phase) begin
                                ts_q     <= m_i_wb_dat;
                                ts_vld_q <= 1'b1;
                                ts_phase <= 1'b0;
                            end else begin
                                cur_word  <= m_i_wb_dat;
                                fetch_cnt <= fetch_cnt + WCW'(1);
                                byte_idx  <= '0;
                            end
                        end else begin
                            cyc_q <= 1'b1;
                        end
                    end
                    UNPACK: begin
                        // Prefetch path: a word landing on the byte-3 handshake goes
                        // straight into the unpack register instead of the spare buffer.
                        if (ack_hit) begin
                            cyc_q     <= 1'b0;
                            adr_q     <= adr_q + ADR_WIDTH'(4);
                            fetch_cnt <= fetch_cnt + WCW'(1);
                            if (last_byte) cur_word <= m_i_wb_dat;
                            else begin
                                nxt_word <= m_i_wb_dat;
                                nxt_vld  <= 1'b1;
                            end
                        end else if (can_prefetch) begin
                            cyc_q <= 1'b1;
                        end
                        if (px_hs) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (col_last) begin
                                col <= '0;
                                row <= row_last ? '0 : row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                            if (last_byte) begin
                                if (col_last && row_last) begin
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else if (nxt_vld) begin
                                    cur_word <= nxt_word;
                                    nxt_vld  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: cyc_q <= 1'b0;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timestamp = ts_q;
    assign ts_vld    = ts_vld_q;
    assign m_wb_cyc  = cyc_q;
    assign m_wb_stb  = cyc_q;
    assign m_wb_adr  = adr_q;
    assign m_wb_we   = 1'b0;
    assign px_vld    = (state == UNPACK);
    assign px_dat    = px_vld ? cur_word[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign px_sof    = px_vld && (row == '0) && (col == '0);
    assign px_eol    = px_vld && col_last;
    assign px_eof    = px_eol && row_last;

endmodule

// File: tb/tb_wb_frame_reader.sv
// tb/tb_wb_frame_reader.sv - self-checking bench for wb_frame_reader with a frame-level reference model
module tb_wb_frame_reader;
    localparam int AW   = 15;
    localparam int ROWS = 2;
    localparam int COLS = 8;
    localparam int NPX  = ROWS * COLS;
    localparam int NW   = 1 + NPX / 4;

    typedef logic [10:0] pix_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, px_rdy = 1'b1;
    logic [AW-1:0] rd_addr_start = '0;
    logic busy, done, ts_vld, cyc, stb, we, px_vld, px_sof, px_eol, px_eof, ack;
    logic [31:0] timestamp, rdat;
    logic [AW-1:0] adr;
    logic [7:0] px_dat;

    wb_frame_reader #(.ADR_WIDTH(AW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rd_addr_start(rd_addr_start),
        .busy(busy), .done(done), .timestamp(timestamp), .ts_vld(ts_vld),
        .m_wb_cyc(cyc), .m_wb_stb(stb), .m_wb_adr(adr), .m_wb_we(we),
        .m_i_wb_dat(rdat), .m_wb_ack(ack),
        .px_dat(px_dat), .px_vld(px_vld), .px_rdy(px_rdy),
        .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // memory slave with programmable wait states
    logic [31:0] mem [0:8191];
    int lat = 0, wcnt = 0;
    bit ack_force = 1'b0, rnd_rdy = 1'b0;
    assign rdat = mem[adr[AW-1:2]];
    assign ack  = ack_force | (cyc & stb & (wcnt >= lat));
    always @(posedge clk) wcnt <= (cyc && stb && !ack) ? wcnt + 1 : 0;

    initial forever begin
        @(posedge clk); #1;
        px_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor
    pix_t got_px[$];
    logic [AW-1:0] got_adr[$];
    int ts_cnt, done_cnt, stab_err, drop_err, max_run, run, min_gap, zero_run;
    bit seen, prev_hold, prev_wait;
    logic [31:0] ts_val;
    pix_t prev_pix, cur_pix;

    initial forever begin
        @(negedge clk);
        cur_pix = {px_dat, px_sof, px_eol, px_eof};
        if (cyc && stb && ack) got_adr.push_back(adr);
        if (ts_vld) begin ts_cnt++; ts_val = timestamp; end
        if (done) done_cnt++;
        if (prev_hold && (!px_vld || cur_pix !== prev_pix)) stab_err++;
        if (prev_wait && !(cyc && stb)) drop_err++;
        prev_wait = cyc && stb && !ack;
        prev_hold = px_vld && !px_rdy;
        prev_pix  = cur_pix;
        if (px_vld && px_rdy) got_px.push_back(cur_pix);
        if (px_vld) begin
            run++;
            if (run > max_run) max_run = run;
            if (seen && zero_run > 0 && zero_run < min_gap) min_gap = zero_run;
            zero_run = 0;
            seen = 1'b1;
        end else begin
            run = 0;
            if (seen) zero_run++;
        end
    end

    task automatic clear_mon();
        got_px.delete(); got_adr.delete();
        ts_cnt = 0; done_cnt = 0; stab_err = 0; drop_err = 0;
        max_run = 0; run = 0; min_gap = 1000; zero_run = 0; seen = 1'b0;
        prev_hold = 1'b0; prev_wait = 1'b0;
    endtask

    // reference frame: word 0 timestamp, then pixels byte 0 first
    logic [31:0] fw [0:NW-1];
    logic [AW-1:0] cur_base;

    task automatic load_frame(input logic [AW-1:0] base, input bit fixed);
        cur_base = base;
        if (fixed) begin
            fw[0] = 32'hCAFEF00D; fw[1] = 32'h03020100; fw[2] = 32'h07060504;
            fw[3] = 32'h0B0A0908; fw[4] = 32'h0F0E0D0C;
        end else begin
            for (int k = 0; k < NW; k++) fw[k] = $urandom;
        end
        for (int k = 0; k < NW; k++) mem[((int'(base) >> 2) + k) % 8192] = fw[k];
    endtask

    function automatic pix_t model_px(input int i);
        logic [31:0] w;
        logic [7:0] d;
        w = fw[1 + i / 4];
        d = w[8 * (i % 4) +: 8];
        return {d, i == 0, (i % COLS) == COLS - 1, i == NPX - 1};
    endfunction

    function automatic logic [AW-1:0] model_adr(input int k);
        return AW'(int'(cur_base) + 4 * k);
    endfunction

    task automatic pulse_start(input logic [AW-1:0] a);
        @(posedge clk); #1;
        rd_addr_start = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) break;
        end
        timed_out = (done_cnt == 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, ts_vld, cyc, stb, we} !== 6'b0) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, ts_vld, cyc, stb, we});
        end
        vectors++;
        if ({px_vld, px_sof, px_eol, px_eof, px_dat} !== 12'h0) begin
            miscompares++; $display("FAIL reset_px got %h want 000", {px_vld, px_sof, px_eol, px_eof, px_dat});
        end
        vectors++;
        if ({adr, timestamp} !== '0) begin
            miscompares++; $display("FAIL reset_adr_ts got %h/%h want 0/0", adr, timestamp);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        clear_mon(); lat = 0; rnd_rdy = 1'b0;
        load_frame(15'h100, 1'b1);
        pulse_start(15'h100);
        wait_done(to);
        vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
        vectors++; if (ts_cnt !== 1 || ts_val !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL basic_ts got %0d x %h want 1 x cafef00d", ts_cnt, ts_val); end
        vectors++; if (got_px.size() != NPX) begin
            miscompares++; $display("FAIL basic_count got %0d want %0d", got_px.size(), NPX); end
        for (int i = 0; i < NPX && i < got_px.size(); i++) begin
            vectors++;
            if (got_px[i] !== model_px(i)) begin
                miscompares++; $display("FAIL basic_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
        end
        vectors++; if (got_adr.size() != NW) begin
            miscompares++; $display("FAIL basic_adr_count got %0d want %0d", got_adr.size(), NW); end
        for (int k = 0; k < NW && k < got_adr.size(); k++) begin
            vectors++;
            if (got_adr[k] !== model_adr(k)) begin
                miscompares++; $display("FAIL basic_adr[%0d] got %h want %h", k, got_adr[k], model_adr(k)); end
        end
        vectors++; if (done_cnt !== 1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_done got %0d busy %b want 1 busy 0", done_cnt, busy); end
`ifdef FRAME_READER_PREFETCH_EN
        vectors++; if (max_run !== NPX) begin
            miscompares++; $display("FAIL prefetch_run got %0d want %0d", max_run, NPX); end
`else
        vectors++; if (max_run !== 4 || min_gap < 2) begin
            miscompares++; $display("FAIL gap got run %0d gap %0d want run 4 gap>=2", max_run, min_gap); end
`endif
    endtask

    task automatic test_rdy_random();
        bit to;
        logic [AW-1:0] base;
        for (int it = 0; it < 3; it++) begin
            clear_mon(); lat = it; rnd_rdy = 1'b1;
            base = AW'($urandom_range(0, 8191) << 2);
            load_frame(base, it == 0);
            pulse_start(base);
            repeat (7) @(posedge clk);
            #1;
            pulse_start(AW'(int'(base) + 64));
            wait_done(to);
            vectors++; if (to || done_cnt !== 1) begin
                miscompares++; $display("FAIL rdy_done[%0d] got %0d want 1", it, done_cnt); end
            vectors++; if (ts_val !== fw[0]) begin
                miscompares++; $display("FAIL rdy_ts[%0d] got %h want %h", it, ts_val, fw[0]); end
            vectors++; if (got_px.size() != NPX) begin
                miscompares++; $display("FAIL rdy_count[%0d] got %0d want %0d", it, got_px.size(), NPX); end
            for (int i = 0; i < NPX && i < got_px.size(); i++) begin
                vectors++;
                if (got_px[i] !== model_px(i)) begin
                    miscompares++; $display("FAIL rdy_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
            end
            for (int k = 0; k < NW && k < got_adr.size(); k++) begin
                vectors++;
                if (got_adr[k] !== model_adr(k)) begin
                    miscompares++; $display("FAIL rdy_adr[%0d] got %h want %h", k, got_adr[k], model_adr(k)); end
            end
            vectors++; if (stab_err !== 0) begin
                miscompares++; $display("FAIL rdy_stable[%0d] got %0d changes want 0", it, stab_err); end
        end
        rnd_rdy = 1'b0;
    endtask

    task automatic test_ack_delay();
        bit to;
        clear_mon(); lat = 3; rnd_rdy = 1'b0;
        load_frame(15'h100, 1'b1);
        pulse_start(15'h100);
        wait_done(to);
        vectors++; if (to || done_cnt !== 1) begin
            miscompares++; $display("FAIL delay_done got %0d want 1", done_cnt); end
        vectors++; if (drop_err !== 0) begin
            miscompares++; $display("FAIL delay_stb_hold got %0d early drops want 0", drop_err); end
        vectors++; if (got_adr.size() != NW) begin
            miscompares++; $display("FAIL delay_acks got %0d want %0d", got_adr.size(), NW); end
        vectors++; if (got_px.size() != NPX) begin
            miscompares++; $display("FAIL delay_count got %0d want %0d", got_px.size(), NPX); end
        for (int i = 0; i < NPX && i < got_px.size(); i++) begin
            vectors++;
            if (got_px[i] !== model_px(i)) begin
                miscompares++; $display("FAIL delay_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
        end
        lat = 0;
    endtask

    task automatic test_wrap();
        bit to;
        clear_mon(); lat = 0;
        load_frame(15'h7FF8, 1'b0);
        pulse_start(15'h7FF8);
        wait_done(to);
        vectors++; if (to || got_adr.size() != NW) begin
            miscompares++; $display("FAIL wrap_acks got %0d want %0d", got_adr.size(), NW); end
        for (int k = 0; k < NW && k < got_adr.size(); k++) begin
            vectors++;
            if (got_adr[k] !== model_adr(k)) begin
                miscompares++; $display("FAIL wrap_adr[%0d] got %h want %h", k, got_adr[k], model_adr(k)); end
        end
        for (int i = 0; i < NPX && i < got_px.size(); i++) begin
            vectors++;
            if (got_px[i] !== model_px(i)) begin
                miscompares++; $display("FAIL wrap_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
        end
    endtask

    task automatic test_abort();
        bit to;
        int n;
        clear_mon(); lat = 0;
        load_frame(15'h100, 1'b1);
        pulse_start(15'h100);
        n = 0;
        while (got_px.size() < 6 && n < 500) begin @(negedge clk); #1; n++; end
        vectors++; if (n >= 500) begin miscompares++; $display("FAIL abort_wait got %0d px want 6", got_px.size()); end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        vectors++; if ({cyc, stb, px_vld, busy} !== 4'b0) begin
            miscompares++; $display("FAIL abort_state got %b want 0000", {cyc, stb, px_vld, busy}); end
        ack_force = 1'b1;
        repeat (2) @(posedge clk);
        #1; ack_force = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (done_cnt !== 0 || busy !== 1'b0 || px_vld !== 1'b0 || ts_cnt !== 1) begin
            miscompares++; $display("FAIL abort_after got done %0d busy %b vld %b ts %0d want 0 0 0 1",
                                    done_cnt, busy, px_vld, ts_cnt); end
        @(posedge clk); #1; start = 1'b1; abort = 1'b1; rd_addr_start = 15'h100;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        vectors++; if ({busy, cyc} !== 2'b00) begin
            miscompares++; $display("FAIL start_abort got %b want 00", {busy, cyc}); end
        clear_mon();
        pulse_start(15'h100);
        wait_done(to);
        vectors++; if (to || got_px.size() != NPX) begin
            miscompares++; $display("FAIL replay_count got %0d want %0d", got_px.size(), NPX); end
        for (int i = 0; i < NPX && i < got_px.size(); i++) begin
            vectors++;
            if (got_px[i] !== model_px(i)) begin
                miscompares++; $display("FAIL replay_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit to;
        clear_mon(); lat = 6;
        load_frame(15'h100, 1'b1);
        pulse_start(15'h100);
        @(negedge clk);
        vectors++; if (cyc !== 1'b1) begin miscompares++; $display("FAIL midfetch_cyc got %b want 1", cyc); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, ts_vld, cyc, stb, px_vld, px_sof, px_eol, px_eof, px_dat, adr, timestamp} !== '0) begin
            miscompares++; $display("FAIL midfetch_reset got busy %b cyc %b adr %h ts %h want all 0",
                                    busy, cyc, adr, timestamp); end
        @(posedge clk); #1; rst_n = 1'b1; lat = 0;
        clear_mon();
        load_frame(15'h240, 1'b0);
        pulse_start(15'h240);
        wait_done(to);
        vectors++; if (to || done_cnt !== 1 || ts_val !== fw[0]) begin
            miscompares++; $display("FAIL fresh_frame got done %0d ts %h want 1 %h", done_cnt, ts_val, fw[0]); end
        for (int i = 0; i < NPX && i < got_px.size(); i++) begin
            vectors++;
            if (got_px[i] !== model_px(i)) begin
                miscompares++; $display("FAIL fresh_px[%0d] got %h want %h", i, got_px[i], model_px(i)); end
        end
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) mem[k] = 32'h0;
        clear_mon();
        test_reset();
        test_basic();
        test_rdy_random();
        test_ack_delay();
        test_wrap();
        test_abort();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
